// File: rtl/adc_capture_buffer.sv
// Capture-then-drain buffer: stores N ADC batches on command, then streams them
// out as one AXI-Stream packet with TLAST on the final beat.
module adc_capture_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int BATCH_SIZE = 4,
  parameter int DEPTH      = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [BATCH_SIZE*DATA_WIDTH-1:0] adc_data,
  input  logic                             adc_valid,
  input  logic                             cmd_start,
  input  logic                             cmd_abort,
  input  logic [$clog2(DEPTH):0]           num_batches,
  output logic [BATCH_SIZE*DATA_WIDTH-1:0] m_tdata,
  output logic                             m_tvalid,
  output logic                             m_tlast,
  input  logic                             m_tready,
  output logic                             busy,
  output logic                             done
);

  localparam int BW = BATCH_SIZE * DATA_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int NW = PW + 1;
  localparam logic [NW-1:0] DEPTH_N = NW'(DEPTH);
  localparam logic [NW-1:0] ONE_N   = NW'(1);

  typedef enum logic [1:0] {IDLE, CAPTURE, SEND} state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [NW-1:0]   n_lat, n_last, n_clamp;
  logic [BW-1:0]   mem [DEPTH];
  logic            wr_en, wr_last, rd_last, xfer, start_ok, done_nx;

  // N is clamped to the buffer depth; a request for zero batches is dropped.
  assign n_clamp  = (num_batches > DEPTH_N) ? DEPTH_N : num_batches;
  assign start_ok = cmd_start && (num_batches != '0);
  assign n_last   = n_lat - ONE_N;
  assign wr_en    = (state == CAPTURE) && adc_valid;
  assign wr_last  = ({1'b0, wr_ptr} == n_last);
  assign rd_last  = ({1'b0, rd_ptr} == n_last);
  assign xfer     = (state == SEND) && m_tready;

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    case (state)
      IDLE:    if (start_ok) state_nx = CAPTURE;
      CAPTURE: if (wr_en && wr_last) state_nx = SEND;
      SEND: begin
        if (xfer && rd_last) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (cmd_abort) begin
      state_nx = IDLE;
      done_nx  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      n_lat  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
      done  <= done_nx;
      if (state == IDLE && start_ok) begin
        n_lat  <= n_clamp;
        wr_ptr <= '0;
      end
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (state == CAPTURE) rd_ptr <= '0;
      else if (xfer)        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sample storage carries no reset; only the pointers qualify its contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= adc_data;
  end

  // Stream outputs depend only on registered state, so they hold while stalled.
  assign m_tvalid = (state == SEND);
  assign m_tlast  = m_tvalid && rd_last;
  assign m_tdata  = m_tvalid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Randomized bench for adc_capture_buffer: a queue of captured batches predicts
// every stream beat, TLAST, busy and done cycle by cycle.
module tb_adc_capture_buffer;
  localparam int DATA_WIDTH = 16;
  localparam int BATCH_SIZE = 4;
  localparam int DEPTH      = 64;
  localparam int BW         = DATA_WIDTH * BATCH_SIZE;
  localparam int NW         = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [BW-1:0] adc_data = '0;
  logic          adc_valid = 1'b0;
  logic          cmd_start = 1'b0;
  logic          cmd_abort = 1'b0;
  logic [NW-1:0] num_batches = '0;
  logic [BW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready = 1'b0;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_bad = 0;

  adc_capture_buffer #(
    .DATA_WIDTH(DATA_WIDTH), .BATCH_SIZE(BATCH_SIZE), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .adc_valid(adc_valid),
    .cmd_start(cmd_start), .cmd_abort(cmd_abort), .num_batches(num_batches),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] rnd_batch();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [BW-1:0] seq_batch(input int i);
    return {16'(4*i + 1), 16'(4*i + 2), 16'(4*i + 3), 16'(4*i + 4)};
  endfunction

  task automatic check_idle(input string tag);
    check_eq({tag, "_tvalid"}, BW'(m_tvalid), '0);
    check_eq({tag, "_busy"},   BW'(busy),     '0);
    check_eq({tag, "_done"},   BW'(done),     '0);
  endtask

  // vpct < 0 selects strictly alternating adc_valid (1,0,1,0...).
  // abort_cap / abort_beat / rst_beat < 0 disable that event.
  task automatic run_packet(input int nb, input int vpct, input int rpct,
                            input int abort_cap, input int abort_beat,
                            input int rst_beat, input bit seq_data);
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] d;
    int n, k, guard;
    bit v, r;
    n = (nb > DEPTH) ? DEPTH : nb;
    num_batches = NW'(nb);
    cmd_start = 1'b1;
    tick;
    cmd_start = 1'b0;
    num_batches = NW'($urandom);
    if (n == 0) begin
      repeat (3) begin
        check_idle("zero_req");
        tick;
      end
      return;
    end
    check_eq("start_busy", BW'(busy), BW'(1));
    guard = 0;
    while (exp_q.size() < n) begin
      if (abort_cap >= 0 && exp_q.size() == abort_cap) begin
        cmd_abort = 1'b1;
        adc_valid = 1'b1;
        adc_data  = rnd_batch();
        tick;
        cmd_abort = 1'b0;
        adc_valid = 1'b0;
        repeat (4) begin
          check_idle("abort_cap");
          tick;
        end
        return;
      end
      v = (vpct < 0) ? ((guard % 2) == 0) : ($urandom_range(99) < vpct);
      d = seq_data ? seq_batch(exp_q.size()) : rnd_batch();
      adc_valid   = v;
      adc_data    = d;
      cmd_start   = ($urandom_range(7) == 0);
      num_batches = NW'($urandom);
      tick;
      adc_valid = 1'b0;
      cmd_start = 1'b0;
      if (v) exp_q.push_back(d);
      if (exp_q.size() < n) begin
        check_eq("cap_tvalid", BW'(m_tvalid), '0);
        check_eq("cap_busy",   BW'(busy),     BW'(1));
      end
      guard++;
      if (guard > 2000) begin
        check_eq("cap_timeout", BW'(exp_q.size()), BW'(n));
        return;
      end
    end
    k = 0;
    guard = 0;
    while (k < n) begin
      check_eq("tvalid", BW'(m_tvalid), BW'(1));
      check_eq("tdata",  m_tdata,       exp_q[k]);
      check_eq("tlast",  BW'(m_tlast),  BW'(k == n - 1));
      check_eq("send_busy", BW'(busy),  BW'(1));
      check_eq("send_done", BW'(done),  '0);
      if (rst_beat >= 0 && k == rst_beat) begin
        rst_n = 1'b0;
        #1;
        check_eq("rst_tvalid", BW'(m_tvalid), '0);
        check_eq("rst_tlast",  BW'(m_tlast),  '0);
        check_eq("rst_tdata",  m_tdata,       '0);
        check_eq("rst_busy",   BW'(busy),     '0);
        check_eq("rst_done",   BW'(done),     '0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick;
        check_idle("post_rst");
        return;
      end
      if (abort_beat >= 0 && k == abort_beat) begin
        cmd_abort = 1'b1;
        m_tready  = $urandom_range(1);
        tick;
        cmd_abort = 1'b0;
        m_tready  = 1'b0;
        check_eq("abort_tlast", BW'(m_tlast), '0);
        repeat (3) begin
          check_idle("abort_send");
          tick;
        end
        return;
      end
      r = ($urandom_range(99) < rpct);
      m_tready    = r;
      adc_valid   = $urandom_range(1);
      adc_data    = rnd_batch();
      cmd_start   = ($urandom_range(7) == 0);
      num_batches = NW'($urandom);
      tick;
      m_tready  = 1'b0;
      adc_valid = 1'b0;
      cmd_start = 1'b0;
      if (r) k++;
      guard++;
      if (guard > 4000) begin
        check_eq("send_timeout", BW'(k), BW'(n));
        return;
      end
    end
    check_eq("end_done",   BW'(done),     BW'(1));
    check_eq("end_tvalid", BW'(m_tvalid), '0);
    check_eq("end_tlast",  BW'(m_tlast),  '0);
    check_eq("end_busy",   BW'(busy),     '0);
    tick;
    check_eq("done_pulse", BW'(done), '0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_tvalid", BW'(m_tvalid), '0);
    check_eq("reset_tlast",  BW'(m_tlast),  '0);
    check_eq("reset_tdata",  m_tdata,       '0);
    check_eq("reset_busy",   BW'(busy),     '0);
    check_eq("reset_done",   BW'(done),     '0);
    #2 rst_n = 1'b1;
    tick;

    run_packet(4, 100, 100, -1, -1, -1, 1'b1);
    tick;
    run_packet(6, 100, 100, -1, -1, 2, 1'b0);
    tick;
    run_packet(3, 100, 100, -1, -1, -1, 1'b1);
    tick;
    run_packet(8, -1, 50, -1, -1, -1, 1'b0);
    tick;
    run_packet(0, 100, 100, -1, -1, -1, 1'b0);
    run_packet(1, 70, 60, -1, -1, -1, 1'b0);
    tick;
    run_packet(DEPTH + 5, 80, 70, -1, -1, -1, 1'b0);
    tick;
    run_packet(DEPTH, 90, 60, -1, -1, -1, 1'b0);
    tick;
    run_packet(10, 100, 100, 3, -1, -1, 1'b0);
    tick;
    run_packet(8, 100, 100, -1, 1, -1, 1'b0);
    tick;
    for (int i = 0; i < 20; i++) begin
      run_packet($urandom_range(80), $urandom_range(100, 30),
                 $urandom_range(100, 30), -1, -1, -1, 1'b0);
      repeat ($urandom_range(2)) tick;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/adc_capture_buffer.md
Name: adc_capture_buffer

Overview:
- Captures a programmable number of ADC sample batches into an internal buffer, then streams them to the processing system over an AXI-Stream master port.
- Sits between the ADC data path (one batch of samples per clock) and the AXI transmit path to the PS.
- Runs a capture-then-drain sequence: each start command fills the buffer, then empties it with a TLAST-delimited packet.

Parameters:
- DATA_WIDTH, 16, bits per ADC sample
- BATCH_SIZE, 4, samples per batch (samples per clock)
- DEPTH, 64, buffer depth in batches (power of two)

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- adc_data  input  BATCH_SIZE*DATA_WIDTH  one batch; sample 0 in LSBs
- adc_valid  input  1  adc_data valid this cycle
- cmd_start  input  1  single-cycle pulse; begins a capture
- cmd_abort  input  1  single-cycle pulse; cancels any operation
- num_batches  input  $clog2(DEPTH)+1  batches to capture; sampled on cmd_start
- m_tdata  output  BATCH_SIZE*DATA_WIDTH  stream data
- m_tvalid  output  1  stream valid
- m_tlast  output  1  high on the final beat of a packet
- m_tready  input  1  stream ready
- busy  output  1  high in CAPTURE or SEND
- done  output  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (asynchronous, active-low): state IDLE, pointers 0; m_tvalid, m_tlast, busy, done all 0; m_tdata 0. Buffer contents need not be reset.
- States: IDLE, CAPTURE, SEND.
- IDLE:
  - cmd_start with num_batches != 0: latch N = min(num_batches, DEPTH), clear write pointer, enter CAPTURE next cycle.
  - cmd_start with num_batches == 0: ignored, stay IDLE, no done pulse.
- CAPTURE:
  - Each cycle with adc_valid=1 writes adc_data to buffer[wr_ptr] and increments wr_ptr.
  - adc_valid=0 cycles are skipped (no write, no increment).
  - When the N-th batch is written, enter SEND on the next cycle with rd_ptr=0.
  - cmd_start in CAPTURE is ignored.
- SEND:
  - m_tvalid=1 and m_tdata=buffer[rd_ptr].
  - m_tlast=1 exactly when rd_ptr==N-1.
  - Beat transfers when m_tvalid && m_tready; rd_ptr increments on each transfer.
  - While m_tready=0, m_tdata, m_tvalid and m_tlast hold stable (AXI-Stream rule).
  - On transfer of the last beat: go to IDLE next cycle, done=1 for exactly that one cycle, m_tvalid and m_tlast drop.
  - adc_valid and cmd_start in SEND are ignored.
- cmd_abort in any state: next cycle IDLE, m_tvalid=0, m_tlast=0, no done pulse; partial data is discarded.
- cmd_abort and cmd_start in the same cycle: abort wins.
- busy = (state != IDLE), registered with the state.
- Latency:
  - First m_tvalid asserts 1 cycle after the clock edge that writes the N-th batch.
  - Data order out equals capture order; no sample reordering within a batch.
- N==DEPTH: the buffer fills exactly; wr_ptr wraps to 0 and is not used further.
- num_batches > DEPTH: clamped to DEPTH.
- N==1: the single beat has m_tlast=1.

Test Plan:
- Reset mid-SEND: assert rst_n=0 while m_tvalid=1 -> m_tvalid, busy, done immediately 0; after release, state IDLE and a new cmd_start capture works.
- Basic capture: num_batches=4, cmd_start, adc_valid=1 for 4 cycles with batches 0x0001_0002_0003_0004 … (incrementing) -> with m_tready=1, 4 beats in the same order; m_tlast only on beat 4; done pulses once; busy falls with it.
- Gapped input and backpressure: num_batches=8, adc_valid toggling 1,0,1,0… -> exactly 8 batches stored. During SEND, m_tready random 50% -> every beat held stable while stalled; 8 beats, no loss or duplication.
- Boundaries:
  - num_batches=0 -> no state change, busy stays 0.
  - num_batches=1 -> one beat with m_tlast=1.
  - num_batches=DEPTH+5 -> exactly DEPTH beats.
- Abort: cmd_abort during CAPTURE after 3 of 10 batches -> IDLE next cycle, no m_tvalid, no done. cmd_abort during SEND at beat 2 -> m_tvalid drops next cycle, no done.
- Ignored commands: second cmd_start during CAPTURE or SEND -> no effect on N or pointers; packet length unchanged.
